// File: rtl/pwm_duty_sequencer_if.sv
// Command handshake between the control/register logic and pwm_duty_sequencer.
interface pwm_duty_sequencer_if;
   logic       cmd_valid;
   logic [7:0] cmd_duty;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd_duty, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Walks the PWM dutyCycle toward a clamped target, committing only on period boundaries.
// Macro PWM_SEQ_RAMP_EN enables stepped ramping; without it the target is committed in one step.
module pwm_duty_sequencer #(
   parameter int RAMP_DIV = 1000,
   parameter int STEP     = 1
) (
   input  logic                        clkin,
   input  logic                        rst_n,
   pwm_duty_sequencer_if.slave         cmd,
   input  logic                        estop,
   input  logic                        period_start,
   output logic [7:0]                  duty_out,
   output logic                        duty_load,
   output logic                        busy,
   output logic                        at_target,
   output logic                        err_range
);

   typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_STOP} state_t;

   if (RAMP_DIV < 1 || RAMP_DIV > 65535 || STEP < 1 || STEP > 100) begin : g_param_check
      $error("pwm_duty_sequencer: RAMP_DIV or STEP out of range");
   end

   state_t     state, state_nx;
   logic [7:0] target, target_nx;
   logic [7:0] duty_nx;
   logic       pend_valid, pend_valid_nx;
   logic [7:0] pend_val, pend_val_nx;
   logic       load_nx, err_nx;
   logic       accept;

   function automatic logic [7:0] clamp_duty(input logic [7:0] d);
      return (d > 8'd100) ? 8'd100 : d;
   endfunction

`ifdef PWM_SEQ_RAMP_EN
   localparam logic [15:0]       TICK_LAST = 16'(RAMP_DIV - 1);
   localparam logic signed [8:0] STEP_S    = 9'(STEP);
   localparam logic [7:0]        STEP_U    = 8'(STEP);

   logic [15:0] tick_cnt, tick_nx;

   // Signed distance decides direction; a short remaining gap lands exactly on the target.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      logic signed [8:0] diff;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      if (diff <= STEP_S && diff >= -STEP_S)
         return tgt;
      else if (diff > 9'sd0)
         return cur + STEP_U;
      else
         return cur - STEP_U;
   endfunction
`endif

   assign cmd.cmd_ready = (state == ST_IDLE) & ~estop;
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;
   assign busy          = (state == ST_RAMP);
   assign at_target     = (duty_out == target) & ~pend_valid;

   always_comb begin
      state_nx      = state;
      target_nx     = target;
      duty_nx       = duty_out;
      pend_valid_nx = pend_valid;
      pend_val_nx   = pend_val;
      load_nx       = 1'b0;
      err_nx        = 1'b0;
`ifdef PWM_SEQ_RAMP_EN
      tick_nx       = tick_cnt;
`endif
      // Emergency stop overrides commit, staging and accept, without waiting for a boundary.
      if (estop) begin
         state_nx      = ST_STOP;
         duty_nx       = 8'd0;
         load_nx       = (duty_out != 8'd0);
         pend_valid_nx = 1'b0;
         target_nx     = 8'd0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  target_nx = clamp_duty(cmd.cmd_duty);
                  err_nx    = (cmd.cmd_duty > 8'd100);
                  state_nx  = ST_RAMP;
`ifdef PWM_SEQ_RAMP_EN
                  tick_nx   = 16'd0;
`else
                  if (clamp_duty(cmd.cmd_duty) != duty_out) begin
                     pend_valid_nx = 1'b1;
                     pend_val_nx   = clamp_duty(cmd.cmd_duty);
                  end
`endif
               end
            end
            ST_RAMP: begin
               if (pend_valid && period_start) begin
                  duty_nx       = pend_val;
                  pend_valid_nx = 1'b0;
                  load_nx       = 1'b1;
               end
               if (duty_out == target && !pend_valid)
                  state_nx = ST_IDLE;
`ifdef PWM_SEQ_RAMP_EN
               else if (pend_valid)
                  tick_nx = 16'd0;
               else if (tick_cnt == TICK_LAST) begin
                  pend_val_nx   = step_toward(duty_out, target);
                  pend_valid_nx = 1'b1;
                  tick_nx       = 16'd0;
               end else
                  tick_nx = tick_cnt + 16'd1;
`endif
            end
            ST_STOP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         target     <= 8'd0;
         duty_out   <= 8'd0;
         pend_valid <= 1'b0;
         pend_val   <= 8'd0;
         duty_load  <= 1'b0;
         err_range  <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
         tick_cnt   <= 16'd0;
`endif
      end else begin
         state      <= state_nx;
         target     <= target_nx;
         duty_out   <= duty_nx;
         pend_valid <= pend_valid_nx;
         pend_val   <= pend_val_nx;
         duty_load  <= load_nx;
         err_range  <= err_nx;
`ifdef PWM_SEQ_RAMP_EN
         tick_cnt   <= tick_nx;
`endif
      end
   end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: directed scenarios plus random targets against a trajectory model.
module tb_pwm_duty_sequencer;
   localparam int RAMP_DIV = 4;
   localparam int STEP     = 10;

   logic       clkin = 1'b0;
   logic       rst_n = 1'b0;
   logic       estop = 1'b0;
   logic       period_start = 1'b0;
   logic [7:0] duty_out;
   logic       duty_load, busy, at_target, err_range;

   int total = 0;
   int bad   = 0;
   int exp_duty = 0;
   int expq[$];

   pwm_duty_sequencer_if cmd_if();

   pwm_duty_sequencer #(.RAMP_DIV(RAMP_DIV), .STEP(STEP)) dut (
      .clkin(clkin), .rst_n(rst_n), .cmd(cmd_if), .estop(estop),
      .period_start(period_start), .duty_out(duty_out), .duty_load(duty_load),
      .busy(busy), .at_target(at_target), .err_range(err_range)
   );

   always #5 clkin = ~clkin;

   // PWM channel stand-in: one-cycle period_start every 8 clocks.
   initial begin
      period_start = 1'b0;
      forever begin
         repeat (7) @(negedge clkin);
         period_start = 1'b1;
         @(negedge clkin);
         period_start = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   // Sequence of committed duty values expected when moving from one duty to a target.
   function automatic void build_expq(input int from, input int to);
      int cur;
      cur = from;
      expq.delete();
`ifdef PWM_SEQ_RAMP_EN
      while (cur != to) begin
         if (to - cur > STEP)      cur = cur + STEP;
         else if (cur - to > STEP) cur = cur - STEP;
         else                      cur = to;
         expq.push_back(cur);
      end
`else
      if (cur != to) expq.push_back(to);
`endif
   endfunction

   task automatic run_cmd(input int duty);
      int         tgt;
      logic [7:0] prev;
      bit         done;
      tgt = (duty > 100) ? 100 : duty;
      build_expq(exp_duty, tgt);
      chk("ready_before_cmd", cmd_if.cmd_ready, 1);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_duty  = 8'(duty);
      tick();
      cmd_if.cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("err_range_after_accept", err_range, (duty > 100));
      prev = duty_out;
      done = 1'b0;
      for (int c = 0; c < 400; c++) begin
         tick();
         chk("err_range_single_pulse", err_range, 0);
         if (duty_load) begin
            chk("load_on_period_start", period_start, 1);
            if (expq.size() == 0) chk("unexpected_load", duty_load, 0);
            else                  chk("duty_step", duty_out, expq.pop_front());
         end else begin
            chk("duty_hold", duty_out, prev);
         end
         prev = duty_out;
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      chk("ramp_finished", done, 1);
      chk("steps_left", expq.size(), 0);
      chk("final_duty", duty_out, tgt);
      chk("at_target_end", at_target, 1);
      chk("ready_end", cmd_if.cmd_ready, 1);
      exp_duty = tgt;
   endtask

   initial begin
      int loads;
      int first_exp;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_duty  = 8'd0;
      rst_n = 1'b0;
      estop = 1'b0;
      repeat (3) @(posedge clkin);
      #1;
      chk("rst_duty_out", duty_out, 0);
      chk("rst_cmd_ready", cmd_if.cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_at_target", at_target, 1);
      chk("rst_duty_load", duty_load, 0);
      chk("rst_err_range", err_range, 0);
      rst_n = 1'b1;
      tick();

      // Ramp up, clamp, ramp down
      run_cmd(35);
      run_cmd(150);
      run_cmd(35);

      // Command equal to the current duty completes in two cycles without a load
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_duty  = 8'd35;
      tick();
      cmd_if.cmd_valid = 1'b0;
      chk("equal_busy", busy, 1);
      chk("equal_load0", duty_load, 0);
      tick();
      chk("equal_done_ready", cmd_if.cmd_ready, 1);
      chk("equal_done_load", duty_load, 0);
      chk("equal_duty", duty_out, 35);

      // Estop with an update pending
      run_cmd(30);
      for (int c = 0; c < 20; c++) begin
         tick();
         if (period_start) break;
      end
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_duty  = 8'd60;
      tick();
      cmd_if.cmd_valid = 1'b0;
      repeat (4) tick();
      chk("estop_pre_duty", duty_out, 30);
      chk("estop_pre_pending", at_target, 0);
      estop = 1'b1;
      tick();
      chk("estop_duty_zero", duty_out, 0);
      chk("estop_load_pulse", duty_load, 1);
      chk("estop_ready", cmd_if.cmd_ready, 0);
      chk("estop_busy", busy, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("estop_hold_duty", duty_out, 0);
         chk("estop_hold_load", duty_load, 0);
         chk("estop_hold_ready", cmd_if.cmd_ready, 0);
      end
      estop = 1'b0;
      tick();
      chk("estop_release_ready", cmd_if.cmd_ready, 1);
      chk("estop_release_at_target", at_target, 1);
      exp_duty = 0;
      run_cmd(20);

      // Reset in the middle of a ramp
      build_expq(exp_duty, 80);
      first_exp = expq[0];
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_duty  = 8'd80;
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (duty_load) break;
      end
      chk("midramp_first_load", duty_load, 1);
      chk("midramp_first_value", duty_out, first_exp);
      rst_n = 1'b0;
      #1;
      chk("midrst_duty", duty_out, 0);
      chk("midrst_load", duty_load, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_at_target", at_target, 1);
      chk("midrst_ready", cmd_if.cmd_ready, 1);
      repeat (2) tick();
      rst_n = 1'b1;
      loads = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (duty_load) loads++;
      end
      chk("postrst_no_loads", loads, 0);
      chk("postrst_duty", duty_out, 0);
      exp_duty = 0;

      // Random targets, including out-of-range values
      for (int i = 0; i < 8; i++) begin
         int d;
         d = int'($urandom_range(0, 130));
         run_cmd(d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
